// File: rtl/vend_pkg.sv
// Shared encodings and helpers for the vending transaction sequencer.
package vend_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_ONE  = 2'b01,
    COIN_TWO  = 2'b10,
    COIN_BAD  = 2'b11
  } coin_t;

  function automatic logic [1:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_ONE: return 2'd1;
      COIN_TWO: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_sequencer_if.sv
// Coin/dispense bus between the acceptor front end, the sequencer
// and the dispense motor driver.
interface vend_sequencer_if #(
  parameter int CREDIT_W = 5
);
  logic [1:0]          coin;
  logic [CREDIT_W-1:0] price;
  logic                cancel;
  logic                disp_ack;
  logic                disp_req;
  logic                change_pulse;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output coin, price, cancel, disp_ack,
    input  disp_req, change_pulse, coin_reject,
    input  credit, busy
  );

  modport slave (
    input  coin, price, cancel, disp_ack,
    output disp_req, change_pulse, coin_reject,
    output credit, busy
  );
endinterface

// File: rtl/vend_timeout_timer.sv
// Idle-cycle counter with terminal-count flag for the COLLECT refund
// timeout; only instantiated when REFUND_TIMEOUT_EN is defined.
module vend_timeout_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_run,
  input  logic i_clr,
  output logic o_tc
);
  localparam int CNT_W =
    (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!i_run || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = i_run && (r_cnt == LAST);
endmodule

// File: rtl/vend_sequencer.sv
// Coin credit / dispense / change sequencer.
// Optional refund timeout in COLLECT: define REFUND_TIMEOUT_EN.
module vend_sequencer #(
  parameter int CREDIT_W    = 5,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic            clock,
  input logic            reset,
  vend_sequencer_if.slave bus
);
  import vend_pkg::*;

  localparam logic [CREDIT_W-1:0] CMAX = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] r_price_q;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic [CREDIT_W-1:0] w_price_nxt;
  logic [CREDIT_W-1:0] w_remain;
  logic [CREDIT_W:0]   w_sum;
  logic [1:0]          w_val;
  logic                w_valid;
  logic                w_ovf;
  logic                w_tmo;
  logic                w_reject;
  logic                w_disp_req_nxt;
  logic                w_change_nxt;
  logic                r_disp_req;
  logic                r_change_pulse;
  logic                r_coin_reject;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  assign w_val    = coin_value(bus.coin);
  assign w_valid  = (w_val != 2'd0);
  assign w_sum    = {1'b0, r_credit} +
                    {{(CREDIT_W-1){1'b0}}, w_val};
  assign w_ovf    = w_sum[CREDIT_W];
  assign w_remain = r_credit - r_price_q;

`ifdef REFUND_TIMEOUT_EN
  logic w_in_collect;
  logic w_accept;

  assign w_in_collect = (r_state == S_COLLECT);
  assign w_accept     = w_in_collect && w_valid &&
                        !bus.cancel;

  vend_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .i_run (w_in_collect),
    .i_clr (w_accept),
    .o_tc  (w_tmo)
  );
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_credit       <= '0;
      r_price_q      <= '0;
      r_disp_req     <= 1'b0;
      r_change_pulse <= 1'b0;
      r_coin_reject  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt;
      r_price_q      <= w_price_nxt;
      r_disp_req     <= w_disp_req_nxt;
      r_change_pulse <= w_change_nxt;
      r_coin_reject  <= w_reject;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_price_nxt  = r_price_q;
    w_reject     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_valid) begin
          if (bus.price == '0) begin
            w_reject = 1'b1;
          end else begin
            w_credit_nxt = CREDIT_W'(w_val);
            w_price_nxt  = bus.price;
            w_state_nxt  = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        // cancel wins; a coin on the same edge is bounced
        if (bus.cancel) begin
          w_reject    = w_valid;
          w_state_nxt = S_CHANGE;
        end else begin
          if (w_valid) begin
            w_credit_nxt = w_ovf ? CMAX
                                 : w_sum[CREDIT_W-1:0];
            w_reject     = w_ovf;
          end
          if (w_credit_nxt >= r_price_q) begin
            w_state_nxt = S_VEND;
          end else if (!w_valid && w_tmo) begin
            w_state_nxt = S_CHANGE;
          end
        end
      end
      S_VEND: begin
        w_reject = w_valid;
        if (bus.disp_ack) begin
          w_credit_nxt = w_remain;
          w_state_nxt  = (w_remain != '0) ? S_CHANGE
                                          : S_IDLE;
        end
      end
      S_CHANGE: begin
        w_reject = w_valid;
        if (r_credit != '0) begin
          w_credit_nxt = r_credit - CREDIT_W'(1);
        end
        if (r_credit <= CREDIT_W'(1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_disp_req_nxt = 1'b0;
    w_change_nxt   = 1'b0;
    unique case (1'b1)
      (w_state_nxt == S_VEND):   w_disp_req_nxt = 1'b1;
      (w_state_nxt == S_CHANGE): w_change_nxt   = 1'b1;
      default: ;
    endcase
  end

  assign bus.disp_req     = r_disp_req;
  assign bus.change_pulse = r_change_pulse;
  assign bus.coin_reject  = r_coin_reject;
  assign bus.credit       = r_credit;
  assign bus.busy         = (r_state == S_VEND) ||
                            (r_state == S_CHANGE);
endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: transaction-level model checked
// every cycle plus hand-computed spot checks per scenario.
`timescale 1ns/1ps
module tb_vend_sequencer;
  localparam int CW   = 3;
  localparam int TO   = 8;
  localparam int CMAX = (1 << CW) - 1;

  localparam int M_IDLE = 0;
  localparam int M_COL  = 1;
  localparam int M_VEND = 2;
  localparam int M_CHG  = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  vend_sequencer_if #(.CREDIT_W(CW)) bus ();

  vend_sequencer #(
    .CREDIT_W    (CW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a mode, an integer credit and the
  // rules for what each coin/cancel/ack does to them.
  int m_mode   = M_IDLE;
  int m_credit = 0;
  int m_price  = 0;
  int m_idle   = 0;
  int m_reject = 0;

  function automatic int val(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b10) return 2;
    return 0;
  endfunction

  always @(posedge clock or posedge reset) begin : model
    int v;
    if (reset) begin
      m_mode = M_IDLE; m_credit = 0; m_price = 0;
      m_idle = 0; m_reject = 0;
    end else begin
      v = val(bus.coin);
      m_reject = 0;
      case (m_mode)
        M_IDLE: if (v > 0) begin
          if (bus.price == 0) m_reject = 1;
          else begin
            m_credit = v; m_price = int'(bus.price);
            m_idle = 0; m_mode = M_COL;
          end
        end
        M_COL: begin
          if (bus.cancel) begin
            if (v > 0) m_reject = 1;
            m_mode = M_CHG;
          end else if (v > 0) begin
            if (m_credit + v > CMAX) begin
              m_credit = CMAX; m_reject = 1;
            end else m_credit = m_credit + v;
            m_idle = 0;
            if (m_credit >= m_price) m_mode = M_VEND;
          end else if (m_credit >= m_price) m_mode = M_VEND;
`ifdef REFUND_TIMEOUT_EN
          else if (m_idle == TO - 1) m_mode = M_CHG;
          else m_idle++;
`endif
        end
        M_VEND: begin
          if (v > 0) m_reject = 1;
          if (bus.disp_ack) begin
            m_credit = m_credit - m_price;
            m_mode = (m_credit > 0) ? M_CHG : M_IDLE;
          end
        end
        default: begin
          if (v > 0) m_reject = 1;
          m_credit = m_credit - 1;
          if (m_credit == 0) m_mode = M_IDLE;
        end
      endcase
    end
  end

  int n_pulse = 0;
  int n_disp  = 0;
  logic prev_req = 1'b0;

  always @(negedge clock) begin
    chk("disp_req", int'(bus.disp_req),
        int'(m_mode == M_VEND));
    chk("change_pulse", int'(bus.change_pulse),
        int'(m_mode == M_CHG));
    chk("busy", int'(bus.busy),
        int'(m_mode == M_VEND || m_mode == M_CHG));
    chk("credit", int'(bus.credit), m_credit);
    chk("coin_reject", int'(bus.coin_reject), m_reject);
    n_pulse += int'(bus.change_pulse);
    if (bus.disp_req && !prev_req) n_disp++;
    prev_req = bus.disp_req;
  end

  task automatic drive(input logic [1:0] c, input logic cn,
                       input logic ak);
    bus.coin = c; bus.cancel = cn; bus.disp_ack = ak;
    @(posedge clock); #1;
    bus.coin = 2'b00; bus.cancel = 1'b0; bus.disp_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(2'b00, 1'b0, 1'b0);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !bus.disp_req; i++) idle(1);
    chk("wait_req", int'(bus.disp_req), 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && bus.busy; i++) idle(1);
    chk("wait_done", int'(bus.busy), 0);
  endtask

  int p0, d0;

  initial begin
    bus.coin = 2'b00; bus.price = '0;
    bus.cancel = 1'b0; bus.disp_ack = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_credit", int'(bus.credit), 0);
    chk("rst_req", int'(bus.disp_req), 0);
    chk("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;
    idle(1);

    // 1: price 3, two 2-unit coins, ack two cycles later
    bus.price = 3'd3; p0 = n_pulse; d0 = n_disp;
    drive(2'b10, 0, 0);
    chk("t1_req_early", int'(bus.disp_req), 0);
    drive(2'b10, 0, 0);
    chk("t1_req", int'(bus.disp_req), 1);
    chk("t1_credit", int'(bus.credit), 4);
    idle(2);
    drive(2'b00, 0, 1);
    chk("t1_req_drop", int'(bus.disp_req), 0);
    wait_done();
    chk("t1_pulses", n_pulse - p0, 1);
    chk("t1_disp", n_disp - d0, 1);

    // 2: exact payment, no change
    bus.price = 3'd2; p0 = n_pulse; d0 = n_disp;
    drive(2'b10, 0, 0);
    wait_req();
    drive(2'b00, 0, 1);
    wait_done();
    chk("t2_pulses", n_pulse - p0, 0);
    chk("t2_disp", n_disp - d0, 1);
    chk("t2_credit", int'(bus.credit), 0);

    // 3: cancel beats a same-edge coin
    bus.price = 3'd4; p0 = n_pulse;
    drive(2'b01, 0, 0);
    drive(2'b10, 1, 0);
    chk("t3_reject", int'(bus.coin_reject), 1);
    chk("t3_credit", int'(bus.credit), 1);
    wait_done();
    chk("t3_pulses", n_pulse - p0, 1);

    // 4: coins bounced in VEND and CHANGE, and at price 0
    bus.price = 3'd2; p0 = n_pulse;
    drive(2'b10, 0, 0);
    drive(2'b10, 0, 0);
    wait_req();
    drive(2'b01, 0, 0);
    chk("t4_rej_vend", int'(bus.coin_reject), 1);
    chk("t4_cred_vend", int'(bus.credit), 4);
    drive(2'b00, 0, 1);
    chk("t4_cred_ack", int'(bus.credit), 2);
    drive(2'b01, 0, 0);
    chk("t4_rej_chg", int'(bus.coin_reject), 1);
    chk("t4_cred_chg", int'(bus.credit), 1);
    wait_done();
    chk("t4_pulses", n_pulse - p0, 2);
    bus.price = 3'd0;
    drive(2'b01, 0, 0);
    chk("t4_rej_p0", int'(bus.coin_reject), 1);
    chk("t4_cred_p0", int'(bus.credit), 0);
    idle(1);
    chk("t4_rej_1cyc", int'(bus.coin_reject), 0);

    // 5: saturation at 7, then reset while vending
    bus.price = 3'd7;
    drive(2'b10, 0, 0);
    drive(2'b10, 0, 0);
    drive(2'b10, 0, 0);
    chk("t5_cred6", int'(bus.credit), 6);
    drive(2'b10, 0, 0);
    chk("t5_sat", int'(bus.credit), 7);
    chk("t5_rej", int'(bus.coin_reject), 1);
    chk("t5_req", int'(bus.disp_req), 1);
    idle(1);
    reset = 1'b1;
    #2;
    chk("t5_rst_req", int'(bus.disp_req), 0);
    chk("t5_rst_cred", int'(bus.credit), 0);
    chk("t5_rst_busy", int'(bus.busy), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(1);

    // 6: refund timeout (or indefinite hold without it)
    bus.price = 3'd5; p0 = n_pulse;
    drive(2'b01, 0, 0);
    idle(7);
    chk("t6_hold", int'(bus.busy), 0);
    chk("t6_cred", int'(bus.credit), 1);
    idle(1);
`ifdef REFUND_TIMEOUT_EN
    chk("t6_tmo_pulse", int'(bus.change_pulse), 1);
    wait_done();
    chk("t6_pulses", n_pulse - p0, 1);
`else
    chk("t6_no_tmo", int'(bus.change_pulse), 0);
    idle(20);
    chk("t6_still", int'(bus.credit), 1);
    drive(2'b00, 1, 0);
    wait_done();
    chk("t6_pulses", n_pulse - p0, 1);
`endif
    chk("t6_end_cred", int'(bus.credit), 0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
